// File: rtl/jit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jit_pkg
// Description : Shared types and constants for the JIT microcode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jit_pkg;

    localparam int ADDR_W = 9;
    localparam int ID_W   = 7;

    // Instruction id the ROM returns for addresses with no programmed entry.
    localparam logic [ID_W-1:0]   INST_INVALID = 7'h7F;
    // Next-address value that terminates a chain.
    localparam logic [ADDR_W-1:0] NEXT_END     = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_UNSUP  = 2'd1;
    localparam logic [1:0] ERR_ROMDEF = 2'd2;
    localparam logic [1:0] ERR_LOOP   = 2'd3;

endpackage : jit_pkg
`default_nettype wire

// File: rtl/jit_microseq.sv
`default_nettype none
// ============================================================================
// Module      : jit_microseq
// Description : Walks the instruction/next-address ROM chain for one JVM
//               opcode and streams the resulting instruction ids to the
//               ARM emitter over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module jit_microseq
    import jit_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int ID_W      = 7,
    parameter int MAX_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              opc_valid,
    output logic              opc_ready,
    input  logic [7:0]        opc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ID_W-1:0]   rom_inst,
    input  logic [ADDR_W-1:0] rom_next,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ID_W-1:0]   inst_id,
    output logic              inst_last,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Sized to hold MAX_STEPS itself, so the counter never wraps.
    localparam int                STEP_W     = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] c_MAX_STEP = STEP_W'(MAX_STEPS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ID_W-1:0]     r_inst;
    logic [ADDR_W-1:0]   r_next;
    logic [STEP_W-1:0]   r_step;
    logic                r_done;
    logic                r_err;
    logic [1:0]          r_err_code;

    logic                w_accept;
    logic                w_load;
    logic                w_advance;
    logic                w_done_nxt;
    logic                w_err_nxt;
    logic [1:0]          w_err_code_nxt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, datapath strobes and stream outputs; flush overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_advance      = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_err_code_nxt = r_err_code;
        opc_ready      = (r_state == IDLE);
        inst_valid     = (r_state == EMIT);
        inst_last      = (r_state == EMIT) && (r_next == NEXT_END);

        if (flush) begin
            // Abort silently; an opcode offered in the same cycle is dropped.
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (opc_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = LOOKUP;
                    end
                end
                LOOKUP: begin
                    if ((rom_inst == '0) && (r_step == '0)) begin
                        // A zero id is only illegal as the first entry of a chain.
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_UNSUP;
                        w_state_nxt    = IDLE;
                    end else if (rom_inst == {ID_W{1'b1}}) begin
                        w_err_nxt      = 1'b1;
                        w_err_code_nxt = ERR_ROMDEF;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = EMIT;
                    end
                end
                EMIT: begin
                    if (inst_ready) begin
                        if (r_next == NEXT_END) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else if (r_step == c_MAX_STEP) begin
                            w_err_nxt      = 1'b1;
                            w_err_code_nxt = ERR_LOOP;
                            w_state_nxt    = IDLE;
                        end else begin
                            w_advance   = 1'b1;
                            w_state_nxt = LOOKUP;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Address, captured ROM outputs, step count and registered status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_inst     <= '0;
            r_next     <= '0;
            r_step     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_accept) begin
                r_addr <= ADDR_W'(opc);
                r_step <= '0;
            end
            if (w_load) begin
                r_inst <= rom_inst;
                r_next <= rom_next;
                r_step <= r_step + STEP_W'(1);
            end
            if (w_advance) begin
                r_addr <= r_next;
            end
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    assign rom_addr = r_addr;
    assign inst_id  = r_inst;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule : jit_microseq
`default_nettype wire

// File: tb/tb_jit_microseq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jit_microseq
// Description : Directed self-checking bench for jit_microseq with a small
//               combinational ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jit_microseq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       opc_valid = 1'b0;
    logic       opc_ready;
    logic [7:0] opc = 8'h00;
    logic [8:0] rom_addr;
    logic [6:0] rom_inst;
    logic [8:0] rom_next;
    logic       inst_valid;
    logic       inst_ready = 1'b0;
    logic [6:0] inst_id;
    logic       inst_last;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [6:0] ids_seen [0:31];
    logic       last_seen [0:31];

    jit_microseq #(
        .ADDR_W    (9),
        .ID_W      (7),
        .MAX_STEPS (16)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .opc_valid  (opc_valid),
        .opc_ready  (opc_ready),
        .opc        (opc),
        .rom_addr   (rom_addr),
        .rom_inst   (rom_inst),
        .rom_next   (rom_next),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_id    (inst_id),
        .inst_last  (inst_last),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // ROM pair model: unprogrammed addresses return the default id 127.
    always_comb begin
        rom_inst = 7'h7F;
        rom_next = 9'h000;
        case (rom_addr)
            9'h022: begin rom_inst = 7'd26; rom_next = 9'h000; end
            9'h00B: begin rom_inst = 7'd11; rom_next = 9'h10B; end
            9'h10B: begin rom_inst = 7'd10; rom_next = 9'h000; end
            9'h000: begin rom_inst = 7'd0;  rom_next = 9'h000; end
            9'h005: begin rom_inst = 7'd2;  rom_next = 9'h100; end
            9'h100: begin rom_inst = 7'd2;  rom_next = 9'h100; end
            9'h010: begin rom_inst = 7'd3;  rom_next = 9'h110; end
            9'h110: begin rom_inst = 7'd0;  rom_next = 9'h111; end
            9'h111: begin rom_inst = 7'd5;  rom_next = 9'h000; end
            default: begin rom_inst = 7'h7F; rom_next = 9'h000; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one opcode and let the chain run with the emitter always ready.
    task automatic run_op(input logic [7:0] op, output int n, output logic got_done,
                          output logic got_err);
        inst_ready = 1'b1;
        opc        = op;
        opc_valid  = 1'b1;
        tick();
        opc_valid  = 1'b0;
        n          = 0;
        got_done   = 1'b0;
        got_err    = 1'b0;
        for (int c = 0; c < 200 && !got_done && !got_err; c++) begin
            if (inst_valid) begin
                if (n < 32) begin
                    ids_seen[n]  = inst_id;
                    last_seen[n] = inst_last;
                end
                n++;
            end
            tick();
            if (done) got_done = 1'b1;
            if (err)  got_err  = 1'b1;
        end
    endtask

    initial begin
        int   n;
        logic gd;
        logic ge;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_opc_ready", 32'(opc_ready), 32'd1);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_inst_last", 32'(inst_last), 32'd0);
        chk("rst_inst_id", 32'(inst_id), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single step with exact cycle timing
        inst_ready = 1'b1;
        opc        = 8'h22;
        opc_valid  = 1'b1;
        tick();
        opc_valid  = 1'b0;
        chk("s1_lookup_ready", 32'(opc_ready), 32'd0);
        chk("s1_lookup_valid", 32'(inst_valid), 32'd0);
        chk("s1_rom_addr", 32'(rom_addr), 32'h022);
        tick();
        chk("s1_valid", 32'(inst_valid), 32'd1);
        chk("s1_id", 32'(inst_id), 32'd26);
        chk("s1_last", 32'(inst_last), 32'd1);
        tick();
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_ready_back", 32'(opc_ready), 32'd1);
        chk("s1_valid_drop", 32'(inst_valid), 32'd0);
        tick();
        chk("s1_done_pulse", 32'(done), 32'd0);

        // Two-step chain
        run_op(8'h0B, n, gd, ge);
        chk("c2_count", 32'(n), 32'd2);
        chk("c2_id0", 32'(ids_seen[0]), 32'd11);
        chk("c2_last0", 32'(last_seen[0]), 32'd0);
        chk("c2_id1", 32'(ids_seen[1]), 32'd10);
        chk("c2_last1", 32'(last_seen[1]), 32'd1);
        chk("c2_done", 32'(gd), 32'd1);
        chk("c2_err", 32'(ge), 32'd0);
        tick();
        chk("c2_done_pulse", 32'(done), 32'd0);

        // Unsupported opcode
        opc       = 8'h00;
        opc_valid = 1'b1;
        tick();
        opc_valid = 1'b0;
        chk("un_lookup_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("un_err", 32'(err), 32'd1);
        chk("un_err_code", 32'(err_code), 32'd1);
        chk("un_valid", 32'(inst_valid), 32'd0);
        chk("un_done", 32'(done), 32'd0);
        tick();
        chk("un_err_pulse", 32'(err), 32'd0);
        chk("un_code_hold", 32'(err_code), 32'd1);

        // ROM default hit
        run_op(8'hCA, n, gd, ge);
        chk("rd_count", 32'(n), 32'd0);
        chk("rd_err", 32'(ge), 32'd1);
        chk("rd_err_code", 32'(err_code), 32'd2);
        tick();

        // Backpressure mid-chain, including a legal zero id at step 2
        inst_ready = 1'b0;
        opc        = 8'h10;
        opc_valid  = 1'b1;
        tick();
        opc_valid  = 1'b0;
        tick();
        chk("bp_id0", 32'(inst_id), 32'd3);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", 32'(inst_valid), 32'd1);
            chk("bp_hold_id", 32'(inst_id), 32'd0);
            chk("bp_hold_last", 32'(inst_last), 32'd0);
            tick();
        end
        chk("bp_still_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        tick();
        tick();
        chk("bp_id2", 32'(inst_id), 32'd5);
        chk("bp_last2", 32'(inst_last), 32'd1);
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_err_code_kept", 32'(err_code), 32'd2);

        // Step overflow on a self-looping chain
        run_op(8'h05, n, gd, ge);
        chk("lp_count", 32'(n), 32'd16);
        chk("lp_err", 32'(ge), 32'd1);
        chk("lp_done", 32'(gd), 32'd0);
        chk("lp_err_code", 32'(err_code), 32'd3);
        for (int k = 0; k < 16; k++) begin
            chk("lp_id", 32'(ids_seen[k]), 32'd2);
        end
        tick();

        // Flush in EMIT
        inst_ready = 1'b0;
        opc        = 8'h22;
        opc_valid  = 1'b1;
        tick();
        opc_valid  = 1'b0;
        tick();
        chk("fl_valid_before", 32'(inst_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid_after", 32'(inst_valid), 32'd0);
        chk("fl_ready", 32'(opc_ready), 32'd1);
        chk("fl_done", 32'(done), 32'd0);
        chk("fl_err", 32'(err), 32'd0);
        tick();
        chk("fl_done2", 32'(done), 32'd0);
        chk("fl_err2", 32'(err), 32'd0);

        // Flush beats an opcode offered in IDLE
        flush     = 1'b1;
        opc       = 8'h0B;
        opc_valid = 1'b1;
        tick();
        flush     = 1'b0;
        opc_valid = 1'b0;
        chk("fi_not_accepted", 32'(opc_ready), 32'd1);
        tick();
        chk("fi_no_emit", 32'(inst_valid), 32'd0);

        // Reset while in LOOKUP
        inst_ready = 1'b1;
        opc        = 8'h22;
        opc_valid  = 1'b1;
        tick();
        opc_valid  = 1'b0;
        chk("rl_in_lookup", 32'(opc_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        chk("rl_opc_ready", 32'(opc_ready), 32'd1);
        chk("rl_inst_valid", 32'(inst_valid), 32'd0);
        chk("rl_inst_id", 32'(inst_id), 32'd0);
        chk("rl_inst_last", 32'(inst_last), 32'd0);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_err", 32'(err), 32'd0);
        chk("rl_err_code", 32'(err_code), 32'd0);
        chk("rl_rom_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_jit_microseq
`default_nettype wire
